uart_mmio: RTL and testbench

//   Memory-mapped UART responder on the picorv32 native bus (sel/ready handshake).

---
 rtl/soc_uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_mmio.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_uart_pkg.sv
// soc_uart_pkg: register offsets, status bit positions, divider floor and FSM
// state encodings shared by the UART TX and RX paths.
package soc_uart_pkg;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    localparam logic [15:0] MIN_DIV = 16'd16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO for received bytes; pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // A push while full is still taken when the head is popped in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: picorv32-bus UART responder, DATA at 0x80000008, CTRL/STATUS at 0x8000000C, 8N1.
// Define UART_RX_FIFO_EN to buffer received bytes in an RX_FIFO_DEPTH-entry FIFO.
module uart_mmio
    import soc_uart_pkg::*;
#(
    parameter int CLK_FREQ      = 27000000,
    parameter int BAUD          = 115200,
    parameter int RX_FIFO_DEPTH = 4
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_sel,
    input  logic        uart_addr,
    input  logic [3:0]  uart_wstrb,
    input  logic [31:0] uart_data_i,
    output logic        uart_ready,
    output logic [31:0] uart_data_o,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);

    logic        ready_q, ready_d, ack_q, ack_d;
    logic [31:0] data_o_q, data_o_d, rd_data, status_word;
    logic [15:0] div_q, div_d, div_merge;
    logic        tx_busy_q, tx_busy_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        is_write, data_wr, fire, tx_accept, rx_pop, ctrl_wr;

    logic [1:0]  tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        tx_q, tx_d, tx_done;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_deliver, rx_frame_bad, rx_full, rx_valid;
    logic [7:0]  rx_rd_byte;
    logic        unused_bits;

    assign uart_ready  = ready_q;
    assign uart_data_o = data_o_q;
    assign uart_tx     = tx_q;
    assign unused_bits = ^{uart_data_i[15:8], uart_wstrb[1], RX_FIFO_DEPTH};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_write  = |uart_wstrb;
        data_wr   = (uart_addr == ADDR_DATA) && uart_wstrb[0];
        fire      = uart_sel && !ack_q && !(data_wr && tx_busy_q);
        tx_accept = fire && data_wr;
        rx_pop    = fire && !is_write && (uart_addr == ADDR_DATA);
        ctrl_wr   = fire && is_write && (uart_addr == ADDR_CTRL);

        status_word               = '0;
        status_word[31:16]        = div_q;
        status_word[ST_FRAME_ERR] = frame_err_q;
        status_word[ST_OVERRUN]   = overrun_q;
        status_word[ST_RX_VALID]  = rx_valid;
        status_word[ST_TX_BUSY]   = tx_busy_q;
        rd_data = (uart_addr == ADDR_DATA) ? {24'b0, rx_rd_byte} : status_word;

        ready_d  = fire;
        ack_d    = uart_sel && (ack_q || fire);
        data_o_d = (fire && !is_write) ? rd_data : '0;

        div_merge = div_q;
        if (uart_wstrb[3]) div_merge[15:8] = uart_data_i[31:24];
        if (uart_wstrb[2]) div_merge[7:0]  = uart_data_i[23:16];
        div_d = (ctrl_wr && (uart_wstrb[3] || uart_wstrb[2])) ? clamp_div(div_merge) : div_q;

        tx_busy_d = tx_accept ? 1'b1 : (tx_done ? 1'b0 : tx_busy_q);

        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (ctrl_wr && uart_wstrb[0] && uart_data_i[2]) overrun_d   = 1'b0;
        if (ctrl_wr && uart_wstrb[0] && uart_data_i[3]) frame_err_d = 1'b0;
        if (rx_deliver && rx_full && !rx_pop)           overrun_d   = 1'b1;
        if (rx_frame_bad)                               frame_err_d = 1'b1;
    end

    // TX: the frame starts the cycle after acceptance and runs on the divider latched then.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != 16'd0) ? tx_cnt_q - 16'd1 : tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_accept ? uart_data_i[7:0] : tx_shift_q;
        tx_d       = tx_q;
        tx_done    = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_busy_q) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = div_q - 16'd1;
                    tx_div_d   = div_q;
                    tx_d       = 1'b0;
                end
            end
            S_START: if (tx_cnt_q == 16'd0) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = tx_div_q - 16'd1;
                tx_bit_d   = 3'd0;
                tx_d       = tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d = tx_div_q - 16'd1;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = S_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            default: if (tx_cnt_q == 16'd0) begin
                tx_state_d = S_IDLE;
                tx_done    = 1'b1;
            end
        endcase
    end

    // RX: start detected on a synchronised falling edge, all samples at bit midpoints.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = (rx_cnt_q != 16'd0) ? rx_cnt_q - 16'd1 : rx_cnt_q;
        rx_div_d     = rx_div_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_deliver   = 1'b0;
        rx_frame_bad = 1'b0;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = (div_q >> 1) - 16'd1;
                rx_div_d   = div_q;
            end
            S_START: if (rx_cnt_q == 16'd0) begin
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                rx_cnt_d   = rx_div_q - 16'd1;
                rx_bit_d   = 3'd0;
            end
            S_DATA: if (rx_cnt_q == 16'd0) begin
                rx_cnt_d   = rx_div_q - 16'd1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            default: if (rx_cnt_q == 16'd0) begin
                rx_state_d   = S_IDLE;
                rx_deliver   = rx_s2_q;
                rx_frame_bad = !rx_s2_q;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_dout;
    logic       fifo_empty;

    uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_deliver),
        .din     (rx_shift_q),
        .pop     (rx_pop),
        .dout    (fifo_dout),
        .full    (rx_full),
        .empty   (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign rx_rd_byte = fifo_empty ? 8'h00 : fifo_dout;
`else
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    // A byte arriving in the same cycle the CPU reads takes the freed slot.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_byte_d  = rx_byte_q;
        if (rx_deliver && (!rx_valid_q || rx_pop)) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign rx_full    = rx_valid_q;
    assign rx_valid   = rx_valid_q;
    assign rx_rd_byte = rx_byte_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            data_o_q    <= '0;
            div_q       <= DIV_RST;
            tx_busy_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= DIV_RST;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= DIV_RST;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            data_o_q    <= data_o_d;
            div_q       <= div_d;
            tx_busy_q   <= tx_busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_s1_q     <= uart_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scenario tasks for uart_mmio checked against a behavioural
// model of the register file, RX holding store and divider.
module tb_uart_mmio;

    localparam int DIV    = 234;
    localparam int MAXLAT = 4000;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_sel = 1'b0;
    logic        uart_addr = 1'b0;
    logic [3:0]  uart_wstrb = 4'h0;
    logic [31:0] uart_data_i = '0;
    logic        uart_ready;
    logic [31:0] uart_data_o;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_checks = 0;
    int n_pass   = 0;
    logic last_tx_at_ready;

    logic [15:0] m_div;
    logic        m_valid, m_ovr, m_ferr;
    logic [7:0]  m_byte;
    logic [7:0]  m_q[$];

    uart_mmio #(.CLK_FREQ(27000000), .BAUD(115200), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_sel    (uart_sel),
        .uart_addr   (uart_addr),
        .uart_wstrb  (uart_wstrb),
        .uart_data_i (uart_data_i),
        .uart_ready  (uart_ready),
        .uart_data_o (uart_data_o),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    function automatic void m_reset();
        m_div = 16'(DIV); m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h00;
        m_q.delete();
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
`ifdef UART_RX_FIFO_EN
        else if (m_q.size() >= DEPTH) m_ovr = 1'b1;
        else m_q.push_back(b);
`else
        else if (m_valid) m_ovr = 1'b1;
        else begin m_byte = b; m_valid = 1'b1; end
`endif
    endfunction

    function automatic logic [31:0] m_read_data();
        logic [7:0] b;
`ifdef UART_RX_FIFO_EN
        b = (m_q.size() == 0) ? 8'h00 : m_q.pop_front();
`else
        b = m_byte;
        m_valid = 1'b0;
`endif
        return {24'b0, b};
    endfunction

    function automatic logic [31:0] m_status();
        logic v;
`ifdef UART_RX_FIFO_EN
        v = (m_q.size() != 0);
`else
        v = m_valid;
`endif
        return {m_div, 12'b0, m_ferr, m_ovr, v, 1'b0};
    endfunction

    function automatic void m_ctrl(input logic [3:0] ws, input logic [31:0] d);
        if (ws[3]) m_div[15:8] = d[31:24];
        if (ws[2]) m_div[7:0]  = d[23:16];
        if ((ws[3] || ws[2]) && m_div < 16) m_div = 16;
        if (ws[0] && d[2]) m_ovr  = 1'b0;
        if (ws[0] && d[3]) m_ferr = 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic addr, input logic [3:0] ws, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        logic got = 1'b0;
        uart_sel = 1'b1; uart_addr = addr; uart_wstrb = ws; uart_data_i = wd;
        lat = 0; rd = '0;
        while (!got && lat < MAXLAT) begin
            tick(1);
            lat++;
            if (uart_ready) begin got = 1'b1; rd = uart_data_o; last_tx_at_ready = uart_tx; end
        end
        uart_sel = 1'b0; uart_wstrb = 4'h0;
        if (!got) begin
            n_checks++;
            $display("FAIL bus_timeout: no ready after %0d cycles (addr %0d wstrb %h)", lat, addr, ws);
        end
        tick(1);
    endtask

    task automatic check_status(input string name);
        logic [31:0] rd; int lat; logic [31:0] exp;
        exp = m_status();
        bus(1'b1, 4'h0, '0, rd, lat);
        n_checks++;
        if (rd !== exp) $display("FAIL %s: status got %h want %h", name, rd, exp); else n_pass++;
    endtask

    task automatic check_data(input string name);
        logic [31:0] rd; int lat; logic [31:0] exp;
        exp = m_read_data();
        bus(1'b0, 4'h0, '0, rd, lat);
        n_checks++;
        if (rd !== exp) $display("FAIL %s: data got %h want %h", name, rd, exp); else n_pass++;
    endtask

    // Call in the first cycle of the start bit; samples each bit at its midpoint.
    task automatic check_tx_frame(input logic [7:0] b, input int div, input string name);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        tick(div / 2);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (uart_tx !== frame[i]) $display("FAIL %s bit%0d: tx got %b want %b", name, i, uart_tx, frame[i]);
            else n_pass++;
            if (i < 9) tick(div);
        end
    endtask

    task automatic wait_tx_start(input int bound);
        int n = 0;
        while (uart_tx !== 1'b0 && n < bound) begin tick(1); n++; end
        if (uart_tx !== 1'b0) begin
            n_checks++;
            $display("FAIL tx_start_timeout: no start bit within %0d cycles", bound);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        uart_rx = 1'b0; tick(div);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(div); end
        uart_rx = stop; tick(div);
        uart_rx = 1'b1; tick(div);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd; int lat; int pulses = 0;
        reset_n = 1'b0; tick(2);
        n_checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", uart_ready); else n_pass++;
        n_checks++; if (uart_data_o !== 32'h0) $display("FAIL reset_data_o: got %h want 0", uart_data_o); else n_pass++;
        reset_n = 1'b1; m_reset(); tick(2);
        bus(1'b1, 4'h0, '0, rd, lat);
        n_checks++; if (rd !== 32'h00EA0000) $display("FAIL reset_status: got %h want 00ea0000", rd); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL read_latency: got %0d want 1", lat); else n_pass++;
        uart_sel = 1'b1; uart_addr = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(1); if (uart_ready) pulses++; end
        uart_sel = 1'b0; tick(1);
        n_checks++; if (pulses !== 1) $display("FAIL ready_pulse: got %0d pulses want 1", pulses); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, rd2; int lat, lat2; logic [7:0] b2;
        b2 = 8'($urandom);
        bus(1'b0, 4'b0001, 32'h55, rd, lat);
        n_checks++; if (lat !== 1) $display("FAIL tx_write_latency: got %0d want 1", lat); else n_pass++;
        n_checks++; if (last_tx_at_ready !== 1'b1) $display("FAIL tx_idle_at_ready: got %b want 1", last_tx_at_ready); else n_pass++;
        n_checks++; if (uart_tx !== 1'b0) $display("FAIL tx_fall_after_ready: got %b want 0", uart_tx); else n_pass++;
        fork
            begin
                check_tx_frame(8'h55, DIV, "tx55");
                wait_tx_start(4 * DIV);
                check_tx_frame(b2, DIV, "tx_b2b");
            end
            bus(1'b0, 4'b0001, {24'b0, b2}, rd2, lat2);
        join
        n_checks++;
        if (lat2 < 10 * DIV - 2 || lat2 > 10 * DIV + 2)
            $display("FAIL b2b_stall: got %0d cycles want about %0d", lat2, 10 * DIV);
        else n_pass++;
        tick(DIV);
        check_status("status_after_tx");
    endtask

    task automatic test_rx();
        send_rx(8'hA5, 1'b1, DIV); m_frame(8'hA5, 1'b1);
        check_status("rx_valid_set");
        check_data("rx_a5");
        check_status("rx_valid_cleared");
    endtask

    task automatic test_overrun();
        send_rx(8'h11, 1'b1, DIV); m_frame(8'h11, 1'b1);
        send_rx(8'h22, 1'b1, DIV); m_frame(8'h22, 1'b1);
        check_status("overrun_status");
        check_data("overrun_first");
`ifdef UART_RX_FIFO_EN
        check_data("fifo_second");
`endif
        begin
            logic [31:0] rd; int lat;
            bus(1'b1, 4'b0001, 32'h4, rd, lat); m_ctrl(4'b0001, 32'h4);
        end
        check_status("overrun_cleared");
    endtask

    task automatic test_frame_err();
        logic [31:0] rd; int lat; logic [7:0] b;
        b = 8'($urandom);
        send_rx(b, 1'b0, DIV); m_frame(b, 1'b0);
        check_status("frame_err_set");
        bus(1'b1, 4'b0001, 32'h8, rd, lat); m_ctrl(4'b0001, 32'h8);
        check_status("frame_err_cleared");
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0; tick(50); uart_rx = 1'b1; tick(2 * DIV);
        check_status("glitch_status");
        check_data("glitch_no_byte");
    endtask

    task automatic test_random();
        logic [31:0] rd; int lat; logic [15:0] d; logic [7:0] tb_byte, rb; logic stop;
        for (int k = 0; k < 6; k++) begin
            d = 16'($urandom_range(8, 48));
            bus(1'b1, 4'b1100, {d, 16'h0}, rd, lat); m_ctrl(4'b1100, {d, 16'h0});
            tb_byte = 8'($urandom);
            bus(1'b0, 4'b0001, {24'b0, tb_byte}, rd, lat);
            n_checks++; if (uart_tx !== 1'b0) $display("FAIL rand_tx_start%0d: got %b want 0", k, uart_tx); else n_pass++;
            check_tx_frame(tb_byte, int'(m_div), "rand_tx");
            tick(int'(m_div));
            rb = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(rb, stop, int'(m_div)); m_frame(rb, stop);
            check_status("rand_status");
            if ($urandom_range(0, 1) == 1) check_data("rand_data");
        end
        bus(1'b1, 4'b0001, 32'hC, rd, lat); m_ctrl(4'b0001, 32'hC);
        check_status("rand_clear");
    endtask

    task automatic test_div_clamp();
        logic [31:0] rd; int lat;
        bus(1'b1, 4'b1100, 32'h0008_0000, rd, lat); m_ctrl(4'b1100, 32'h0008_0000);
        bus(1'b1, 4'h0, '0, rd, lat);
        n_checks++; if (rd[31:16] !== 16'd16) $display("FAIL div_clamp: got %0d want 16", rd[31:16]); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] rd; int lat;
        bus(1'b0, 4'b0001, 32'h00, rd, lat);
        tick(3 * int'(m_div));
        n_checks++; if (uart_tx !== 1'b0) $display("FAIL mid_tx_low: got %b want 0", uart_tx); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx_high: got %b want 1", uart_tx); else n_pass++;
        tick(2);
        reset_n = 1'b1; m_reset(); tick(2);
        bus(1'b1, 4'h0, '0, rd, lat);
        n_checks++; if (rd !== 32'h00EA0000) $display("FAIL status_after_reset: got %h want 00ea0000", rd); else n_pass++;
        tick(12 * DIV);
        n_checks++; if (uart_tx !== 1'b1) $display("FAIL tx_idle_after_reset: got %b want 1", uart_tx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_random();
        test_div_clamp();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
